// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream valid/ready,
// downstream valid/ready, squash and occupancy.
interface pipe_stage_reg_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FIELDS = 5
);
  localparam int W = DATA_WIDTH * NUM_FIELDS;

  logic [W-1:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
  logic         i_flush;
  logic [1:0]   o_count;

  modport slave (
    input  i_data, i_valid, i_ready, i_flush,
    output o_ready, o_data, o_valid, o_count
  );

  modport master (
    output i_data, i_valid, i_ready, i_flush,
    input  o_ready, o_data, o_valid, o_count
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer.
// Flush squashes both entries and loads a NOP bubble.
module pipe_stage_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_FIELDS = 5,
  parameter int                    NOP_FIELD  = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic           clk,
  input  logic           i_rst_n,
  pipe_stage_reg_if.slave bus
);
  typedef logic [NUM_FIELDS-1:0][DATA_WIDTH-1:0] bundle_t;

  // Bit 0 is the main valid, bit 1 the skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t  state_q, state_d;
  bundle_t main_q, main_d, skid_q, skid_d, bubble, in_data;
  logic    rdy_q, rdy_d;
  logic    push, pop, main_valid, skid_valid;

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_bub
    assign bubble[k] = (k == NOP_FIELD) ? NOP_VALUE : '0;
  end

  assign in_data    = bus.i_data;
  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];
  assign push       = bus.i_valid & rdy_q;
  assign pop        = main_valid & bus.i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.i_flush) begin
      state_d = EMPTY;
      main_d  = bubble;
      skid_d  = bubble;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          main_d  = in_data;
        end
        ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.o_ready = rdy_q;
  assign bus.o_valid = main_valid;
  assign bus.o_data  = main_q;
  assign bus.o_count = {1'b0, main_valid} + {1'b0, skid_valid};
endmodule
